// File: rtl/rpn_stack_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for the
// RPN stack command sequencer.
package rpn_stack_ctrl_pkg;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP1 = 2'd1,
    S_POP2 = 2'd2,
    S_PUSH = 2'd3
  } state_t;

  function automatic logic is_binop(input logic [2:0] op);
    return (op != OP_PUSH) && (op != OP_POP) && (op != OP_DUP);
  endfunction

endpackage

// File: rtl/rpn_stack_ctrl_alu.sv
// Combinational two-operand ALU. a is the newer (top) entry, b the older one;
// SUB yields b - a, arithmetic wraps modulo 2**B.
module rpn_alu
  import rpn_stack_ctrl_pkg::*;
#(
  parameter int B = 8
) (
  input  logic [2:0]   i_op,
  input  logic [B-1:0] i_a,
  input  logic [B-1:0] i_b,
  output logic [B-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_b + i_a;
      OP_SUB:  o_y = i_b - i_a;
      OP_AND:  o_y = i_b & i_a;
      OP_OR:   o_y = i_b | i_a;
      OP_XOR:  o_y = i_b ^ i_a;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Command sequencer in front of a Lifo: turns single-cycle RPN commands into
// Lifo pop/push sequences, tracking depth and sticky under/overflow flags.
//
// state | meaning
// IDLE  | ready for a command; preconditions checked against r_depth
// POP1  | pop newest entry (a); POP finishes here with the result
// POP2  | pop older entry (b); compute b OP a into write data
// PUSH  | push write data; binary ops also publish it as the result
module rpn_stack_ctrl
  import rpn_stack_ctrl_pkg::*;
#(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cmd_valid,
  input  logic [2:0]   i_cmd_op,
  input  logic [B-1:0] i_cmd_data,
  output logic         o_cmd_ready,
  input  logic         i_err_clr,
  output logic         o_stk_rd,
  output logic         o_stk_wr,
  output logic [B-1:0] o_stk_w_data,
  input  logic [B-1:0] i_stk_r_data,
  input  logic         i_stk_full,
  input  logic         i_stk_empty,
  output logic [B-1:0] o_result,
  output logic         o_result_valid,
  output logic [W:0]   o_depth,
  output logic         o_err_underflow,
  output logic         o_err_overflow
);

  localparam logic [W:0] DEPTH_MAX = {1'b1, {W{1'b0}}};
  localparam logic [W:0] ONE       = {{W{1'b0}}, 1'b1};
  localparam logic [W:0] TWO       = ONE << 1;

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_op, w_op_nxt;
  logic [B-1:0] r_a, w_a_nxt;
  logic [B-1:0] r_w_data, w_w_data_nxt;
  logic [B-1:0] r_result, w_result_nxt;
  logic         r_result_valid, w_result_valid_nxt;
  logic [W:0]   r_depth, w_depth_nxt;
  logic         r_err_u, r_err_o;
  logic         w_set_u, w_set_o;
  logic [B-1:0] w_alu_y;

  rpn_alu #(.B(B)) u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (i_stk_r_data),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_op           <= OP_PUSH;
      r_a            <= '0;
      r_w_data       <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_depth        <= '0;
      r_err_u        <= 1'b0;
      r_err_o        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_op           <= w_op_nxt;
      r_a            <= w_a_nxt;
      r_w_data       <= w_w_data_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_depth        <= w_depth_nxt;
      // a new error in the same cycle as err_clr still lands
      r_err_u        <= w_set_u | (r_err_u & ~i_err_clr);
      r_err_o        <= w_set_o | (r_err_o & ~i_err_clr);
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_op_nxt           = r_op;
    w_a_nxt            = r_a;
    w_w_data_nxt       = r_w_data;
    w_result_nxt       = r_result;
    w_result_valid_nxt = 1'b0;
    w_depth_nxt        = r_depth;
    w_set_u            = 1'b0;
    w_set_o            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd_op)
            OP_PUSH: begin
              if (r_depth == DEPTH_MAX) begin
                w_set_o = 1'b1;
              end else begin
                w_op_nxt     = i_cmd_op;
                w_w_data_nxt = i_cmd_data;
                w_state_nxt  = S_PUSH;
              end
            end
            OP_POP: begin
              if (r_depth == '0) begin
                w_set_u = 1'b1;
              end else begin
                w_op_nxt    = i_cmd_op;
                w_state_nxt = S_POP1;
              end
            end
            OP_DUP: begin
              if (r_depth == '0) begin
                w_set_u = 1'b1;
              end else if (r_depth == DEPTH_MAX) begin
                w_set_o = 1'b1;
              end else begin
                w_op_nxt     = i_cmd_op;
                w_w_data_nxt = i_stk_r_data;
                w_state_nxt  = S_PUSH;
              end
            end
            default: begin
              if (r_depth < TWO) begin
                w_set_u = 1'b1;
              end else begin
                w_op_nxt    = i_cmd_op;
                w_state_nxt = S_POP1;
              end
            end
          endcase
        end
      end
      S_POP1: begin
        w_a_nxt     = i_stk_r_data;
        w_depth_nxt = r_depth - ONE;
        if (r_op == OP_POP) begin
          w_result_nxt       = i_stk_r_data;
          w_result_valid_nxt = 1'b1;
          w_state_nxt        = S_IDLE;
        end else begin
          w_state_nxt = S_POP2;
        end
      end
      S_POP2: begin
        w_w_data_nxt = w_alu_y;
        w_depth_nxt  = r_depth - ONE;
        w_state_nxt  = S_PUSH;
      end
      S_PUSH: begin
        w_depth_nxt = r_depth + ONE;
        if (is_binop(r_op)) begin
          w_result_nxt       = r_w_data;
          w_result_valid_nxt = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Lifo status must agree with our own depth; disagreement is flagged
    if (i_stk_empty != (r_depth == '0))      w_set_u = 1'b1;
    if (i_stk_full  != (r_depth == DEPTH_MAX)) w_set_o = 1'b1;
  end

  assign o_cmd_ready     = (r_state == S_IDLE);
  assign o_stk_rd        = (r_state == S_POP1) || (r_state == S_POP2);
  assign o_stk_wr        = (r_state == S_PUSH);
  assign o_stk_w_data    = r_w_data;
  assign o_result        = r_result;
  assign o_result_valid  = r_result_valid;
  assign o_depth         = r_depth;
  assign o_err_underflow = r_err_u;
  assign o_err_overflow  = r_err_o;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl paired with a behavioural Lifo; results are
// checked through a scoreboard of (value, cycle) expectations.
module tb_rpn_stack_ctrl;

  localparam int B = 8;
  localparam int W = 2;
  localparam logic [2:0] C_PUSH = 3'b000, C_POP = 3'b001, C_ADD = 3'b010,
                         C_SUB = 3'b011, C_AND = 3'b100, C_OR = 3'b101,
                         C_XOR = 3'b110, C_DUP = 3'b111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_op = 3'b000;
  logic [B-1:0] cmd_data = '0;
  logic         err_clr = 1'b0;
  logic         cmd_ready, stk_rd, stk_wr, stk_full, stk_empty;
  logic [B-1:0] stk_w_data, stk_r_data, result;
  logic         result_valid, err_u, err_o;
  logic [W:0]   depth;

  always #10 clk = ~clk;

  rpn_stack_ctrl #(.B(B), .W(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
    .i_cmd_data(cmd_data), .o_cmd_ready(cmd_ready), .i_err_clr(err_clr),
    .o_stk_rd(stk_rd), .o_stk_wr(stk_wr), .o_stk_w_data(stk_w_data),
    .i_stk_r_data(stk_r_data), .i_stk_full(stk_full), .i_stk_empty(stk_empty),
    .o_result(result), .o_result_valid(result_valid), .o_depth(depth),
    .o_err_underflow(err_u), .o_err_overflow(err_o)
  );

  // behavioural Lifo
  logic [B-1:0] mem [4];
  int           ptr = 0;
  int           rd_cnt = 0, wr_cnt = 0;
  assign stk_r_data = (ptr == 0) ? '0 : mem[ptr-1];
  assign stk_full   = (ptr == 4);
  assign stk_empty  = (ptr == 0);
  always @(posedge clk) begin
    if (reset) ptr <= 0;
    else if (stk_wr && ptr < 4) begin mem[ptr] <= stk_w_data; ptr <= ptr + 1; end
    else if (stk_rd && ptr > 0) ptr <= ptr - 1;
    if (!reset && stk_rd) rd_cnt <= rd_cnt + 1;
    if (!reset && stk_wr) wr_cnt <= wr_cnt + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [B-1:0] val; int at; } exp_t;
  exp_t       sb[$];
  logic [B-1:0] model[$];
  logic       exp_u = 1'b0, exp_o = 1'b0;
  int         n_pass = 0, n_total = 0;

  always @(negedge clk) begin
    if (!reset) begin
      n_total++;
      if (stk_rd && stk_wr) $display("FAIL rd_wr_exclusive: rd=%b wr=%b required not both", stk_rd, stk_wr);
      else n_pass++;
      if (result_valid) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL unexpected_result: result=%h at cycle %0d, none required", result, cyc);
        else begin
          exp_t e;
          e = sb.pop_front();
          if (result !== e.val || cyc !== e.at)
            $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d", result, cyc, e.val, e.at);
          else n_pass++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete(); model.delete(); exp_u = 1'b0; exp_o = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
  endtask

  task automatic check_state(input string tag);
    n_total++;
    if (depth !== (W+1)'(model.size()) || err_u !== exp_u || err_o !== exp_o)
      $display("FAIL %s: depth=%0d uf=%b of=%b, required depth=%0d uf=%b of=%b",
               tag, depth, err_u, err_o, model.size(), exp_u, exp_o);
    else n_pass++;
  endtask

  task automatic exec(input logic [2:0] op, input logic [B-1:0] d, input string tag);
    int n = model.size();
    logic [B-1:0] a, b, y;
    bit has_res = 0;
    int lat = 0;
    bit seen = 0;
    y = '0;
    case (op)
      C_PUSH: if (n >= 4) exp_o = 1'b1; else model.push_back(d);
      C_POP:  if (n < 1) exp_u = 1'b1; else begin y = model.pop_back(); has_res = 1; lat = 1; end
      C_DUP:  if (n < 1) exp_u = 1'b1; else if (n >= 4) exp_o = 1'b1;
              else begin a = model[n-1]; model.push_back(a); end
      default: if (n < 2) exp_u = 1'b1;
        else begin
          a = model.pop_back(); b = model.pop_back();
          case (op)
            C_ADD: y = b + a;
            C_SUB: y = b - a;
            C_AND: y = b & a;
            C_OR:  y = b | a;
            default: y = b ^ a;
          endcase
          model.push_back(y); has_res = 1; lat = 3;
        end
    endcase
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    if (has_res) sb.push_back('{y, cyc + lat});
    cmd_valid = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1;
    end
    n_total++;
    if (!seen) $display("FAIL %s_ready_timeout: cmd_ready=%b required 1 within 8 cycles", tag, cmd_ready);
    else n_pass++;
    check_state(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_total++;
    if (depth !== '0 || result !== '0 || result_valid !== 1'b0 || stk_rd !== 1'b0 ||
        stk_wr !== 1'b0 || stk_w_data !== '0 || err_u !== 1'b0 || err_o !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL %s: depth=%0d res=%h rv=%b rd=%b wr=%b wd=%h uf=%b of=%b rdy=%b, required all 0 and rdy=1",
               tag, depth, result, result_valid, stk_rd, stk_wr, stk_w_data, err_u, err_o, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_values");
  endtask

  task automatic test_sub_basic();
    exec(C_PUSH, 8'h05, "t1_push5");
    exec(C_PUSH, 8'h03, "t1_push3");
    exec(C_SUB,  8'h00, "t1_sub");
  endtask

  task automatic test_wrap();
    do_reset();
    exec(C_PUSH, 8'h03, "t2_push3");
    exec(C_PUSH, 8'h05, "t2_push5");
    exec(C_SUB,  8'h00, "t2_sub_wrap");
    exec(C_PUSH, 8'hFF, "t2_pushff");
    exec(C_PUSH, 8'h01, "t2_push01");
    exec(C_ADD,  8'h00, "t2_add_wrap");
    exec(C_POP,  8'h00, "t2_pop_sum");
    exec(C_POP,  8'h00, "t2_pop_diff");
  endtask

  task automatic test_underflow();
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_ADD;
    @(posedge clk); #1;
    cmd_valid = 1'b0; exp_u = 1'b1;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL t3_ready_next: cmd_ready=%b required 1", cmd_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    check_state("t3_underflow");
    n_total++;
    if (rd_cnt !== 0) $display("FAIL t3_no_rd: rd pulses=%0d required 0", rd_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    exec(C_PUSH, 8'h01, "t4_p1");
    exec(C_PUSH, 8'h02, "t4_p2");
    exec(C_PUSH, 8'h03, "t4_p3");
    exec(C_PUSH, 8'h04, "t4_p4");
    exec(C_PUSH, 8'h09, "t4_p9_overflow");
    n_total++;
    if (wr_cnt !== 4) $display("FAIL t4_wr_count: wr pulses=%0d required 4", wr_cnt);
    else n_pass++;
    exec(C_DUP, 8'h00, "t4_dup_overflow");
    n_total++;
    if (wr_cnt !== 4) $display("FAIL t4_dup_wr_count: wr pulses=%0d required 4", wr_cnt);
    else n_pass++;
    exec(C_AND, 8'h00, "t4_and");
    exec(C_OR,  8'h00, "t4_or");
    exec(C_POP, 8'h00, "t4_pop");
  endtask

  task automatic test_dup_xor_clr();
    do_reset();
    exec(C_PUSH, 8'h5A, "t5_push");
    exec(C_DUP,  8'h00, "t5_dup");
    exec(C_XOR,  8'h00, "t5_xor");
    exec(C_POP,  8'h00, "t5_pop");
    exec(C_POP,  8'h00, "t5_pop_empty");
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    exp_u = 1'b0; exp_o = 1'b0;
    check_state("t5_err_clr");
    // error raised in the same cycle as err_clr must stick
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_POP; err_clr = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; err_clr = 1'b0; exp_u = 1'b1;
    check_state("t5_err_beats_clr");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    exec(C_PUSH, 8'h11, "t6_pa");
    exec(C_PUSH, 8'h22, "t6_pb");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_ADD;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (stk_rd !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL t6_in_pop2: rd=%b rdy=%b required rd=1 rdy=0", stk_rd, cmd_ready);
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t6_reset_mid");
    @(negedge clk); reset = 1'b0;
    sb.delete(); model.delete(); exp_u = 1'b0; exp_o = 1'b0;
    exec(C_PUSH, 8'h07, "t6_push7");
    exec(C_POP,  8'h00, "t6_pop7");
  endtask

  task automatic test_drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sub_basic();
    test_wrap();
    test_underflow();
    test_overflow();
    test_dup_xor_clr();
    test_reset_mid_op();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
